matrix_scan_ctrl: RTL and testbench

Scan sequencer for the 16-column x 64-row seven-segment LED matrix.
- Reads 8-bit pixel intensities from the double-buffered frame RAM that the SPI loader fills.
- Serialises one bit-plane per column into the shift-register drivers (sdi/sclk/le/oe).
- Applies binary-code-modulation (BCM) brightness.
- Swaps frame buffers with the loader at frame boundaries through a req/ack handshake.

---
 rtl/matrix_scan_ctrl_if.sv | 38 +++
 rtl/matrix_scan_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_matrix_scan_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : matrix_scan_ctrl_if
// Purpose  : Frame-RAM read port, buffer-swap handshake and LED driver pins
//            of the matrix scan sequencer.
// Revision : 1.0
// ============================================================================
interface matrix_scan_ctrl_if #(
  parameter int COLS = 16,
  parameter int ROWS = 64
);
  localparam int c_COL_W = $clog2(COLS);
  localparam int c_ROW_W = $clog2(ROWS);

  logic                       enable;
  logic [c_COL_W+c_ROW_W:0]   fb_raddr;
  logic [7:0]                 fb_rdata;
  logic                       frame_swap_req;
  logic                       frame_swap_ack;
  logic                       buf_sel;
  logic                       frame_done;
  logic [c_COL_W-1:0]         cols;
  logic                       sdi;
  logic                       sclk;
  logic                       le;
  logic                       oe;

  modport master (
    input  enable, fb_rdata, frame_swap_req,
    output fb_raddr, frame_swap_ack, buf_sel, frame_done, cols, sdi, sclk, le, oe
  );

  modport slave (
    output enable, fb_rdata, frame_swap_req,
    input  fb_raddr, frame_swap_ack, buf_sel, frame_done, cols, sdi, sclk, le, oe
  );
endinterface
`default_nettype wire

// File: rtl/matrix_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : matrix_scan_ctrl
// Purpose  : BCM scan sequencer for the column-scanned LED matrix; optional
//            gamma stage enabled by defining MATRIX_GAMMA_EN.
// Revision : 1.0
// ============================================================================
module matrix_scan_ctrl #(
  parameter int COLS         = 16,
  parameter int ROWS         = 64,
  parameter int PLANES       = 8,
  parameter int BASE_TICKS   = 4,
  parameter int BLANK_CYCLES = 4
) (
  input  logic               clk_50,
  input  logic               rst,
  matrix_scan_ctrl_if.master bus
);
  localparam int c_COL_W    = $clog2(COLS);
  localparam int c_ROW_W    = $clog2(ROWS);
  localparam int c_PL_W     = $clog2(PLANES);
  localparam int c_ADDR_W   = 1 + c_COL_W + c_ROW_W;
  localparam int c_DISP_MAX = BASE_TICKS << (PLANES - 1);
  localparam int c_SPAN_A   = (c_DISP_MAX > 2 * ROWS) ? c_DISP_MAX : 2 * ROWS;
  localparam int c_SPAN     = (c_SPAN_A > BLANK_CYCLES) ? c_SPAN_A : BLANK_CYCLES;
  localparam int c_CNT_W    = $clog2(c_SPAN + 1);
`ifdef MATRIX_GAMMA_EN
  localparam int c_FETCH_CYCLES = 2;
  localparam bit c_ISSUE_ON_LOW = 1'b1;
`else
  localparam int c_FETCH_CYCLES = 1;
  localparam bit c_ISSUE_ON_LOW = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_SHIFT   = 3'd2,
    S_LATCH   = 3'd3,
    S_DISPLAY = 3'd4,
    S_BLANK   = 3'd5
  } state_t;

  state_t              r_state, w_state_next;
  logic [c_CNT_W-1:0]  r_cnt, w_cnt_next;
  logic [c_PL_W-1:0]   r_plane, w_plane_next;
  logic [c_COL_W-1:0]  r_col, w_col_next;
  logic                r_buf, w_buf_next;
  logic                r_sdi, w_sdi_next;
  logic [c_ADDR_W-1:0] r_raddr, w_addr;
  logic [c_ROW_W-1:0]  w_row;
  logic [c_CNT_W-1:0]  w_disp_len;
  logic [7:0]          w_pix;
  logic                w_bit;

`ifdef MATRIX_GAMMA_EN
  // Gamma pixel is registered, which is why FETCH and the address lead grow by one.
  logic [7:0] r_gpix;
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) r_gpix <= '0;
    else     r_gpix <= 8'((16'(bus.fb_rdata) * 16'(bus.fb_rdata)) >> 8);
  end
  assign w_pix = r_gpix;
`else
  assign w_pix = bus.fb_rdata;
`endif

  // Rows go out highest first; each row owns a low/high sclk pair of cycles.
  assign w_row      = c_ROW_W'(ROWS - 1) - r_cnt[c_ROW_W:1];
  assign w_bit      = w_pix[r_plane];
  assign w_disp_len = c_CNT_W'(BASE_TICKS) << r_plane;

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_plane <= '0;
      r_col   <= '0;
      r_buf   <= 1'b0;
      r_sdi   <= 1'b0;
      r_raddr <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_plane <= w_plane_next;
      r_col   <= w_col_next;
      r_buf   <= w_buf_next;
      r_sdi   <= w_sdi_next;
      r_raddr <= w_addr;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_cnt_next         = r_cnt;
    w_plane_next       = r_plane;
    w_col_next         = r_col;
    w_buf_next         = r_buf;
    w_sdi_next         = r_sdi;
    w_addr             = r_raddr;
    bus.oe             = 1'b1;
    bus.le             = 1'b0;
    bus.sclk           = 1'b0;
    bus.sdi            = r_sdi;
    bus.frame_done     = 1'b0;
    bus.frame_swap_ack = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        if (bus.enable) w_state_next = S_FETCH;
      end
      S_FETCH: begin
        if (r_cnt == '0) w_addr = {r_buf, r_col, c_ROW_W'(ROWS - 1)};
        if (r_cnt == c_CNT_W'(c_FETCH_CYCLES - 1)) begin
          w_cnt_next   = '0;
          w_state_next = S_SHIFT;
        end else begin
          w_cnt_next = r_cnt + c_CNT_W'(1);
        end
      end
      S_SHIFT: begin
        if (!r_cnt[0]) begin
          bus.sdi    = w_bit;
          w_sdi_next = w_bit;
        end else begin
          bus.sclk = 1'b1;
        end
        if (r_cnt[0] != c_ISSUE_ON_LOW) w_addr = {r_buf, r_col, w_row - c_ROW_W'(1)};
        if (r_cnt == c_CNT_W'(2 * ROWS - 1)) begin
          w_cnt_next   = '0;
          w_state_next = S_LATCH;
        end else begin
          w_cnt_next = r_cnt + c_CNT_W'(1);
        end
      end
      S_LATCH: begin
        bus.le       = 1'b1;
        w_cnt_next   = '0;
        w_state_next = S_DISPLAY;
      end
      S_DISPLAY: begin
        bus.oe = 1'b0;
        if (r_cnt == w_disp_len - c_CNT_W'(1)) begin
          w_cnt_next   = '0;
          w_state_next = S_BLANK;
        end else begin
          w_cnt_next = r_cnt + c_CNT_W'(1);
        end
      end
      S_BLANK: begin
        if (r_cnt == c_CNT_W'(BLANK_CYCLES - 1)) begin
          w_cnt_next   = '0;
          w_state_next = S_FETCH;
          if (r_plane == c_PL_W'(PLANES - 1)) begin
            w_plane_next = '0;
            w_col_next   = r_col + c_COL_W'(1);
            if (r_col == c_COL_W'(COLS - 1)) begin
              // Frame boundary: the only point where enable and swap requests act.
              bus.frame_done = 1'b1;
              if (bus.frame_swap_req) begin
                bus.frame_swap_ack = 1'b1;
                w_buf_next         = ~r_buf;
              end
              if (!bus.enable) w_state_next = S_IDLE;
            end
          end else begin
            w_plane_next = r_plane + c_PL_W'(1);
          end
        end else begin
          w_cnt_next = r_cnt + c_CNT_W'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign bus.fb_raddr = w_addr;
  assign bus.cols     = r_col;
  assign bus.buf_sel  = r_buf;
endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_scan_ctrl
// Purpose  : Scoreboard bench for matrix_scan_ctrl (slot words, display
//            lengths, frame boundaries, swap handshake, async reset).
// Revision : 1.0
// ============================================================================
module tb_matrix_scan_ctrl;
  localparam int COLS         = 16;
  localparam int ROWS         = 64;
  localparam int PLANES       = 8;
  localparam int BASE_TICKS   = 4;
  localparam int BLANK_CYCLES = 4;
  localparam int c_COL_W      = 4;
  localparam int c_ROW_W      = 6;
`ifdef MATRIX_GAMMA_EN
  localparam int c_FRAME_LEN  = 33600;   // 16 * (8*135 + 1020)
`else
  localparam int c_FRAME_LEN  = 33472;   // 16 * (8*134 + 1020)
`endif

  typedef struct {
    logic        b;
    int          col;
    int          plane;
    logic [63:0] word;
    int          disp;
  } slot_t;

  typedef struct {
    int   cyc;
    logic ack;
  } fd_t;

  logic       clk_50 = 1'b0;
  logic       rst    = 1'b0;
  logic [7:0] mem [0:2047];
  slot_t      exp_q[$];
  fd_t        fd_q[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;

  matrix_scan_ctrl_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

  matrix_scan_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .PLANES(PLANES),
    .BASE_TICKS(BASE_TICKS), .BLANK_CYCLES(BLANK_CYCLES)
  ) u_dut (
    .clk_50 (clk_50),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_50 = ~clk_50;

  // Frame RAM: data valid one cycle after the address.
  always @(posedge clk_50) bus.fb_rdata <= mem[bus.fb_raddr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] pix(input logic [7:0] p);
`ifdef MATRIX_GAMMA_EN
    logic [15:0] sq;
    sq = p * p;
    return sq[15:8];
`else
    return p;
`endif
  endfunction

  // Expected slots in scan order from col 0 plane 0 of buffer b.
  task automatic push_slots(input logic b, input int n);
    slot_t      s;
    logic [7:0] px;
    for (int k = 0; k < n; k++) begin
      s.b     = b;
      s.col   = k / PLANES;
      s.plane = k % PLANES;
      s.disp  = BASE_TICKS << s.plane;
      s.word  = '0;
      for (int r = 0; r < ROWS; r++) begin
        px = pix(mem[int'(b) * 1024 + s.col * 64 + r]);
        s.word[r] = px[s.plane];
      end
      exp_q.push_back(s);
    end
  endtask

  task automatic check_reset(input string name);
    chk(name, {42'd0, bus.oe, bus.le, bus.sclk, bus.sdi, bus.cols, bus.buf_sel,
               bus.fb_raddr, bus.frame_swap_ack, bus.frame_done}, 64'h20_0000);
  endtask

  task automatic step();
    @(negedge clk_50);
    #1;
  endtask

  // Monitor: pops expectations whenever the DUT latches a slot or ends a frame.
  initial begin : monitor
    logic [63:0] cap;
    int          nbits, dcnt, oe_viol, col_bad;
    bit          in_disp, buf_chk;
    logic        exp_buf;
    slot_t       cur;
    fd_t         f;
    cap = '0; nbits = 0; dcnt = 0; oe_viol = 0; col_bad = 0;
    in_disp = 0; buf_chk = 0; exp_buf = 1'b0;
    forever begin
      @(negedge clk_50);
      cyc++;
      if (rst) begin
        cap = '0; nbits = 0; dcnt = 0; oe_viol = 0; col_bad = 0;
        in_disp = 0; buf_chk = 0;
      end else begin
        if (buf_chk) begin
          chk("buf_sel_after_eof", bus.buf_sel, exp_buf);
          buf_chk = 0;
        end
        if (bus.sclk) begin
          cap = {cap[62:0], bus.sdi};
          nbits++;
          if (!bus.oe) oe_viol++;
        end
        if (bus.le) begin
          chk("slot_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            chk("shift_word", cap, cur.word);
            chk("shift_bits", nbits, ROWS);
            chk("latch_cols", bus.cols, cur.col);
            chk("raddr_buf", bus.fb_raddr[c_COL_W+c_ROW_W], cur.b);
            chk("raddr_col", bus.fb_raddr[c_ROW_W +: c_COL_W], cur.col);
            chk("oe_high_in_shift", oe_viol, 0);
            in_disp = 1;
          end
          cap = '0; nbits = 0; oe_viol = 0; dcnt = 0; col_bad = 0;
        end else if (in_disp) begin
          if (!bus.oe) begin
            dcnt++;
            if (bus.cols != c_COL_W'(cur.col)) col_bad++;
          end else begin
            chk("oe_low_len", dcnt, cur.disp);
            chk("cols_stable", col_bad, 0);
            in_disp = 0;
          end
        end
        if (bus.frame_done || bus.frame_swap_ack) begin
          chk("frame_expected", fd_q.size() != 0, 1);
          if (fd_q.size() != 0) begin
            f = fd_q.pop_front();
            chk("frame_done_cycle", cyc, f.cyc);
            chk("frame_done_pulse", bus.frame_done, 1);
            chk("swap_ack", bus.frame_swap_ack, f.ack);
            exp_buf = bus.buf_sel ^ f.ack;
            buf_chk = 1;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit ok;
    for (int i = 0; i < 1024; i++) mem[i] = 8'hFF;
    for (int i = 1024; i < 2048; i++) mem[i] = 8'h00;
    mem[1024 + 3 * 64 + 10] = 8'h05;
    bus.enable         = 1'b0;
    bus.frame_swap_req = 1'b0;
    bus.fb_rdata       = 8'h00;
    #1 rst = 1'b1;
    repeat (3) step();
    check_reset("reset_values");
    rst = 1'b0;
    repeat (3) step();
    chk("idle_oe_blank", bus.oe, 1);

    // Frame 0 from buffer 0 (all 0xFF); swap requested mid-frame, enable dropped in col 7.
    push_slots(1'b0, COLS * PLANES);
    fd_q.push_back('{cyc + c_FRAME_LEN, 1'b1});
    bus.enable = 1'b1;
    ok = 0;
    for (int k = 0; k < 40000 && !ok; k++) begin step(); ok = (bus.cols == 4); end
    chk("reach_col4_f0", ok, 1);
    bus.frame_swap_req = 1'b1;
    ok = 0;
    for (int k = 0; k < 40000 && !ok; k++) begin step(); ok = (bus.cols == 7); end
    chk("reach_col7_f0", ok, 1);
    chk("no_ack_midframe", bus.frame_swap_ack, 0);
    bus.enable = 1'b0;
    ok = 0;
    for (int k = 0; k < 40000 && !ok; k++) begin step(); ok = bus.frame_swap_ack; end
    chk("swap_ack_seen", ok, 1);
    step();
    bus.frame_swap_req = 1'b0;
    chk("buf_sel_swapped", bus.buf_sel, 1);
    repeat (200) step();
    chk("idle_after_frame_oe", bus.oe, 1);
    chk("idle_after_frame_cols", bus.cols, 0);
    chk("frame0_slots_consumed", exp_q.size(), 0);
    chk("frame0_done_consumed", fd_q.size(), 0);

    // Frame 1 from buffer 1 (single pixel 0x05 at col 3 row 10); reset during col 4 display.
    push_slots(1'b1, 4 * PLANES + 1);
    bus.enable = 1'b1;
    ok = 0;
    for (int k = 0; k < 12000 && !ok; k++) begin step(); ok = (bus.cols == 4); end
    chk("reach_col4_f1", ok, 1);
    ok = 0;
    for (int k = 0; k < 300 && !ok; k++) begin step(); ok = !bus.oe; end
    chk("reach_display_f1", ok, 1);
    #1 rst = 1'b1;
    #1 check_reset("async_reset_values");
    chk("frame1_slots_consumed", exp_q.size(), 0);
    repeat (3) step();

    // Restart after reset: col 0 plane 0 of buffer 0.
    push_slots(1'b0, 2);
    rst = 1'b0;
    ok = 0;
    for (int k = 0; k < 600 && !ok; k++) begin step(); ok = (exp_q.size() == 0); end
    chk("restart_slots_seen", ok, 1);
    repeat (20) step();
    chk("restart_cols", bus.cols, 0);
    chk("restart_buf_sel", bus.buf_sel, 0);
    rst = 1'b1;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
